nco_clken: RTL
==============

NCO_CLKEN -- requirements
Module: nco_clken

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 32, phase-accumulator width in bits (16..48).
REQ-003 SHALL have parameter INC_DEFAULT, default 32'h15555555, reset increment for every channel (refclk/12 at ACC_W=32).
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, settle count before locked asserts (1..255).
REQ-005 SHALL have port refclk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port cfg_wr  input  1  one-cycle increment-write strobe.
REQ-008 SHALL have port cfg_ch  input  3  target channel index for cfg_wr.
REQ-009 SHALL have port cfg_inc  input  ACC_W  new phase increment.
REQ-010 SHALL have port cfg_ack  output  1  one-cycle write acknowledge.
REQ-011 SHALL have port ce  output  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-012 SHALL have port locked  output  1  high when all enables are stable and valid.

Function
REQ-013 Each channel SHALL hold an ACC_W-bit accumulator acc[i] and an ACC_W-bit increment inc[i].
REQ-014 Every cycle acc[i] SHALL become (acc[i]+inc[i]) mod 2^ACC_W; the carry-out SHALL be registered as raw_ce[i] (one-cycle latency).
REQ-015 ce[i] SHALL equal raw_ce[i] AND locked; ce SHALL never be high while locked is low.
REQ-016 Long-run ce[i] rate SHALL equal inc[i]/2^ACC_W of refclk, with no cumulative drift (exact fractional accumulation).
REQ-017 inc[i]=0 SHALL yield ce[i] permanently low; inc[i]=2^ACC_W-1 SHALL yield ce[i] high on all but one cycle in 2^ACC_W.
REQ-018 cfg_wr with cfg_ch<NUM_CH SHALL load inc[cfg_ch]<=cfg_inc at that clock edge; new value used from the following cycle.
REQ-019 cfg_ack SHALL pulse high exactly one cycle after every cfg_wr, including writes with cfg_ch>=NUM_CH, which change no state.
REQ-020 Back-to-back cfg_wr on consecutive cycles SHALL each be accepted and acknowledged; no stall exists.
REQ-021 Lock FSM states: SETTLE, LOCKED; counter lock_cnt 8 bits.
REQ-022 SETTLE: locked=0, lock_cnt increments each cycle; at lock_cnt=LOCK_CYCLES-1 transition to LOCKED next cycle.
REQ-023 LOCKED: locked=1; a valid cfg_wr (cfg_ch<NUM_CH) SHALL transition to SETTLE with lock_cnt=0, locked low on the next cycle.
REQ-024 A valid cfg_wr during SETTLE SHALL restart lock_cnt at 0.
REQ-025 Invalid-channel writes SHALL not affect the lock FSM.

Reset
REQ-026 While rst high: acc[i]=0, inc[i]=INC_DEFAULT, raw_ce=0, ce=0, cfg_ack=0, locked=0, FSM=SETTLE, lock_cnt=0.
REQ-027 Reset assertion SHALL take effect immediately (asynchronously), including mid-write or mid-settle; cfg_wr coincident with reset SHALL be discarded.
REQ-028 locked SHALL first assert LOCK_CYCLES cycles after the first refclk edge following rst deassertion.

Configuration
REQ-029 Macro NCO_CLKEN_SYNC_RESTART_EN, when defined, SHALL clear all acc[i] to 0 on any valid cfg_wr, phase-aligning every channel.
REQ-030 Without NCO_CLKEN_SYNC_RESTART_EN, accumulators SHALL continue uninterrupted and only the written inc[i] changes.

Verification
REQ-031 Reset release, defaults: locked rises cycle 16; ce[0] then pulses every 12 cycles (with one 13-cycle gap per 2^32/12 residue), ce[1] identical.
REQ-032 Write ch0 inc=32'h80000000: cfg_ack next cycle, locked low next cycle for 16 cycles, then ce[0] pulses every 2 cycles.
REQ-033 Write ch0 inc=0 -> ce[0] never pulses after lock; write cfg_ch=5 (NUM_CH=2) -> cfg_ack pulses, locked stays high, ce unchanged.
REQ-034 Writes ch0 and ch1 on consecutive cycles -> two cfg_ack pulses; locked returns 16 cycles after second write.
REQ-035 rst asserted mid-SETTLE -> ce, locked, cfg_ack zero immediately without clock; inc restored to 32'h15555555.
REQ-036 With NCO_CLKEN_SYNC_RESTART_EN, ch0 and ch1 both inc=32'h40000000 after one write -> ce[0] and ce[1] pulse on identical cycles; without the macro, pre-existing phase offset persists.

Source files
------------

// File: rtl/nco_clken.sv
// rtl/nco_clken.sv - multi-channel NCO clock-enable generator with lock supervision
// Optional macro NCO_CLKEN_SYNC_RESTART_EN: every valid config write zeroes all accumulators.
module nco_clken #(
   parameter int               NUM_CH      = 2,
   parameter int               ACC_W       = 32,
   parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(32'h15555555),
   parameter int               LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic [2:0]        cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic              cfg_ack,
   output logic [NUM_CH-1:0] ce,
   output logic              locked
);

   typedef enum logic {SETTLE, LOCKED} lock_state_t;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);

   logic [ACC_W-1:0]  acc [NUM_CH];
   logic [ACC_W-1:0]  inc [NUM_CH];
   logic [NUM_CH-1:0] raw_ce;
   logic              valid_wr;
   lock_state_t       state, state_n;
   logic [7:0]        lock_cnt, lock_cnt_n;

   assign valid_wr = cfg_wr && ({1'b0, cfg_ch} < 4'(NUM_CH));

   // The accumulator carry-out is the raw enable; a write only takes effect on the next add.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            inc[i] <= INC_DEFAULT;
         end
         raw_ce <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            {raw_ce[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, inc[i]};
`ifdef NCO_CLKEN_SYNC_RESTART_EN
            if (valid_wr) acc[i] <= '0;
`endif
            if (valid_wr && (cfg_ch == 3'(i))) inc[i] <= cfg_inc;
         end
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         cfg_ack  <= 1'b0;
         state    <= SETTLE;
         lock_cnt <= '0;
      end else begin
         cfg_ack  <= cfg_wr;
         state    <= state_n;
         lock_cnt <= lock_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      lock_cnt_n = lock_cnt;
      case (state)
         SETTLE: begin
            if (valid_wr) begin
               lock_cnt_n = '0;
            end else if (lock_cnt == LOCK_LAST) begin
               state_n    = LOCKED;
               lock_cnt_n = '0;
            end else begin
               lock_cnt_n = lock_cnt + 8'd1;
            end
         end
         LOCKED: begin
            if (valid_wr) begin
               state_n    = SETTLE;
               lock_cnt_n = '0;
            end
         end
         default: begin
            state_n    = SETTLE;
            lock_cnt_n = '0;
         end
      endcase
   end

   assign locked = (state == LOCKED);
   assign ce     = raw_ce & {NUM_CH{locked}};

endmodule
